// File: rtl/debug_trace_if.sv
// Trace capture and readout bundle for debug_trace.
// The master drives fetch strobes and the read-side ready.
// The slave (the trace buffer) returns the readout stream.
// The stamp field is only present when DEBUG_TRACE_STAMP_EN is defined.
interface debug_trace_if #(
  parameter int CYC_W = 32
);
`ifdef DEBUG_TRACE_STAMP_EN
  localparam bit STAMP_ON = 1'b1;
`else
  localparam bit STAMP_ON = 1'b0;
`endif
  localparam int ENT_W = (STAMP_ON ? CYC_W : 0) + 28;

  logic             fetch;
  logic [15:0]      pc;
  logic [7:0]       ir;
  logic [3:0]       flags;
  logic             rd_valid;
  logic             rd_ready;
  logic             rd_last;
  logic [ENT_W-1:0] rd_data;

  modport master (
    output fetch, pc, ir, flags, rd_ready,
    input  rd_valid, rd_last, rd_data
  );

  modport slave (
    input  fetch, pc, ir, flags, rd_ready,
    output rd_valid, rd_last, rd_data
  );
endinterface

// File: rtl/debug_trace.sv
// Instruction trace buffer.
// While armed, the circular buffer records one entry per fetch.
// A pc match fires the trigger, and post_cnt further fetches are then recorded.
// Afterwards the buffer is read out oldest-first over a valid/ready stream.
// Optional feature macro DEBUG_TRACE_STAMP_EN adds a free-running cycle counter.
// When it is defined, the counter value is stored in the MSBs of every entry.
//
// state | meaning
// IDLE  | nothing captured or readout finished; fetches ignored
// ARMED | recording every fetch, waiting for the trigger pc
// POST  | trigger seen, recording the remaining post-trigger fetches
// DONE  | capture finished, streaming entries out; fetches ignored
module debug_trace #(
  parameter int DEPTH = 16,
  parameter int CYC_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  debug_trace_if.slave             tr,
  input  logic                     arm_i,
  input  logic                     trig_en_i,
  input  logic [15:0]              trig_pc_i,
  input  logic [$clog2(DEPTH)-1:0] post_cnt_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     triggered_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef DEBUG_TRACE_STAMP_EN
  localparam bit STAMP_ON = 1'b1;
`else
  localparam bit STAMP_ON = 1'b0;
`endif
  localparam int ENT_W = (STAMP_ON ? CYC_W : 0) + 28;

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_e;

  state_e           state_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    remain_q;
  logic [CW-1:0]    count_q;
  logic             trig_q;
  logic             rd_valid_q;
  logic             rd_last_q;
  logic [ENT_W-1:0] mem_q [DEPTH];

  logic             capture;
  logic             trig_hit;
  logic             xfer;
  logic [ENT_W-1:0] entry_d;
  logic [AW-1:0]    wr_ptr_d;
  logic [CW-1:0]    count_d;
  logic [AW-1:0]    oldest_d;

`ifdef DEBUG_TRACE_STAMP_EN
  logic [CYC_W-1:0] cyc_q;

  // Free-running cycle stamp, restarted from zero by arm
  always_ff @(posedge clk) begin
    if (!rst || arm_i) cyc_q <= '0;
    else               cyc_q <= cyc_q + CYC_W'(1);
  end

  assign entry_d = {cyc_q, tr.pc, tr.ir, tr.flags};
`else
  assign entry_d = {tr.pc, tr.ir, tr.flags};
`endif

  // Arm wins over a coincident fetch, and reset blocks any write on its edge.
  assign capture  = rst && !arm_i && tr.fetch && ((state_q == ARMED) || (state_q == POST));
  assign trig_hit = (state_q == ARMED) && trig_en_i && (tr.pc == trig_pc_i);
  assign xfer     = (state_q == DONE) && rd_valid_q && tr.rd_ready;

  // Pointer and count as they stand after this capture.
  assign wr_ptr_d = wr_ptr_q + AW'(1);
  assign count_d  = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
  // Oldest entry: write pointer minus valid count, modulo DEPTH.
  // Before any wrap this is always 0; once the buffer is full it equals the write pointer.
  assign oldest_d = wr_ptr_d - count_d[AW-1:0];

  // Trace storage: written on capture only, never reset
  always_ff @(posedge clk) begin
    if (capture) mem_q[wr_ptr_q] <= entry_d;
  end

  // Capture / readout controller
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      remain_q   <= '0;
      count_q    <= '0;
      trig_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else if (arm_i) begin
      state_q    <= ARMED;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      remain_q   <= '0;
      count_q    <= '0;
      trig_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ARMED, POST: begin
          if (tr.fetch) begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (trig_hit) begin
              trig_q <= 1'b1;
              if (post_cnt_i == '0) begin
                state_q    <= DONE;
                rd_ptr_q   <= oldest_d;
                rd_valid_q <= 1'b1;
                rd_last_q  <= (count_d == CW'(1));
              end else begin
                remain_q <= post_cnt_i;
                state_q  <= POST;
              end
            end else if (state_q == POST) begin
              remain_q <= remain_q - AW'(1);
              if (remain_q == AW'(1)) begin
                state_q    <= DONE;
                rd_ptr_q   <= oldest_d;
                rd_valid_q <= 1'b1;
                rd_last_q  <= (count_d == CW'(1));
              end
            end
          end
        end
        DONE: begin
          if (xfer) begin
            rd_ptr_q  <= rd_ptr_q + AW'(1);
            count_q   <= count_q - CW'(1);
            rd_last_q <= (count_q == CW'(2));
            if (count_q == CW'(1)) begin
              state_q    <= IDLE;
              rd_valid_q <= 1'b0;
              rd_last_q  <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy_o      = (state_q == ARMED) || (state_q == POST);
  assign done_o      = (state_q == DONE);
  assign triggered_o = trig_q;
  assign count_o     = count_q;
  assign tr.rd_valid = rd_valid_q;
  assign tr.rd_last  = rd_last_q;
  assign tr.rd_data  = mem_q[rd_ptr_q];
endmodule

// File: tb/tb_debug_trace.sv
// Scoreboard bench for debug_trace (DEPTH=8).
// The reference model keeps a plain list of everything captured since arm.
// On completion it queues the last DEPTH entries for the readout monitor.
module tb_debug_trace;
  localparam int DEPTH = 8;
  localparam int CYC_W = 32;
  localparam int AW    = 3;
  localparam int CW    = 4;
`ifdef DEBUG_TRACE_STAMP_EN
  localparam int ENT_W = CYC_W + 28;
`else
  localparam int ENT_W = 28;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          arm = 1'b0;
  logic          trig_en = 1'b0;
  logic [15:0]   trig_pc = '0;
  logic [AW-1:0] post_cnt = '0;
  logic          busy, done, triggered;
  logic [CW-1:0] count;

  debug_trace_if #(.CYC_W(CYC_W)) tif();

  debug_trace #(.DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .tr(tif),
    .arm_i(arm), .trig_en_i(trig_en), .trig_pc_i(trig_pc), .post_cnt_i(post_cnt),
    .busy_o(busy), .done_o(done), .triggered_o(triggered), .count_o(count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [ENT_W-1:0] data;
    bit               last;
  } exp_t;
  typedef enum {M_IDLE, M_ARMED, M_POST, M_DONE} mph_t;

  exp_t             exp_q[$];
  logic [ENT_W-1:0] log_q[$];
  mph_t             m_ph = M_IDLE;
  logic [CYC_W-1:0] m_cyc = '0;
  bit               m_trig = 1'b0;
  int               m_rem = 0;
  int               m_cnt;
  bit               m_done;
  bit               m_busy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [ENT_W-1:0] make_entry(input logic [CYC_W-1:0] s, input logic [15:0] p,
                                                  input logic [7:0] i, input logic [3:0] f);
`ifdef DEBUG_TRACE_STAMP_EN
    return {s, p, i, f};
`else
    return {p, i, f} | ENT_W'(s & '0);
`endif
  endfunction

  // Completion: the readout is the last DEPTH captures, oldest first.
  function automatic void finish_capture();
    int n = (log_q.size() > DEPTH) ? DEPTH : log_q.size();
    for (int i = log_q.size() - n; i < log_q.size(); i++) begin
      exp_t e;
      e.data = log_q[i];
      e.last = (i == log_q.size() - 1);
      exp_q.push_back(e);
    end
    m_ph = M_DONE;
  endfunction

  // Reference model, evaluated on the stimulus seen at each rising edge.
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      m_ph = M_IDLE; m_cyc = '0; m_trig = 1'b0;
      log_q.delete(); exp_q.delete();
    end else if (arm) begin
      m_ph = M_ARMED; m_cyc = '0; m_trig = 1'b0;
      log_q.delete(); exp_q.delete();
    end else begin
      if (m_ph == M_DONE && exp_q.size() == 0) begin
        m_ph = M_IDLE;
      end else if (tif.fetch && (m_ph == M_ARMED || m_ph == M_POST)) begin
        log_q.push_back(make_entry(m_cyc, tif.pc, tif.ir, tif.flags));
        if (m_ph == M_ARMED) begin
          if (trig_en && tif.pc == trig_pc) begin
            m_trig = 1'b1;
            m_rem = int'(post_cnt);
            if (m_rem == 0) finish_capture();
            else m_ph = M_POST;
          end
        end else begin
          m_rem--;
          if (m_rem == 0) finish_capture();
        end
      end
      m_cyc = m_cyc + 1;
    end
  end

  // Monitor: check status every cycle, and pop/compare on each readout beat.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      m_done = (m_ph == M_DONE);
      m_busy = (m_ph == M_ARMED || m_ph == M_POST);
      m_cnt  = m_done ? exp_q.size() : (m_busy ? ((log_q.size() > DEPTH) ? DEPTH : log_q.size()) : 0);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("triggered", triggered, m_trig);
      chk("count", count, m_cnt);
      chk("rd_valid", tif.rd_valid, m_done);
      chk("rd_last", tif.rd_last, m_done && exp_q.size() > 0 && exp_q[0].last);
      if (tif.rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got data %h expected no entry", tif.rd_data);
        end else begin
          chk(tif.rd_ready ? "rd_data" : "rd_data_stall", tif.rd_data, exp_q[0].data);
          if (tif.rd_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input bit a, input bit f, input logic [15:0] p);
    arm = a; tif.fetch = f; tif.pc = p;
    tif.ir = 8'($urandom); tif.flags = 4'($urandom);
    @(posedge clk); #1;
    arm = 1'b0; tif.fetch = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, other: random ready
  task automatic drain(input int mode, input int budget);
    int k = 0;
    while (done && budget > 0) begin
      case (mode)
        0:       tif.rd_ready = 1'b1;
        1:       tif.rd_ready = (k % 4 == 0) || (k % 4 == 3);
        default: tif.rd_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      k++; budget--;
    end
    tif.rd_ready = 1'b0;
    chk("drain_timeout", done, 1'b0);
  endtask

  initial begin
    tif.fetch = 1'b0; tif.pc = '0; tif.ir = '0; tif.flags = '0; tif.rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1; chk_en = 1'b1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_count", count, 0);

    // three fetches, trigger on the last, no post-trigger fetches
    trig_en = 1'b1; trig_pc = 16'h0102; post_cnt = 0;
    step(1, 0, 16'h0);
    step(0, 1, 16'h0100); step(0, 1, 16'h0101); step(0, 1, 16'h0102);
    chk("A_done", done, 1'b1);
    chk("A_count", count, 3);
    chk("A_first_pc", tif.rd_data[27:12], 16'h0100);
    drain(0, 20);

    // twelve fetches wrap the buffer; readout is pc 4..B with a stalling consumer
    trig_pc = 16'h0009; post_cnt = 2;
    step(1, 0, 16'h0);
    for (int i = 0; i < 12; i++) step(0, 1, 16'(i));
    chk("B_done", done, 1'b1);
    chk("B_count", count, 8);
    chk("B_first_pc", tif.rd_data[27:12], 16'h0004);
    drain(1, 60);

    // arm together with a fetch: that fetch is dropped, stamps restart at 0
    trig_pc = 16'h0202; post_cnt = 0;
    step(1, 1, 16'h0200);
    step(0, 1, 16'h0201);
    step(0, 0, 16'h0); step(0, 0, 16'h0);
    step(0, 1, 16'h0202);
    chk("C_count", count, 2);
    chk("C_first_pc", tif.rd_data[27:12], 16'h0201);
`ifdef DEBUG_TRACE_STAMP_EN
    chk("C_first_stamp", tif.rd_data[ENT_W-1:28], 0);
`endif
    drain(0, 20);

    // reset during POST with two fetches still due
    trig_pc = 16'h0300; post_cnt = 3;
    step(1, 0, 16'h0);
    step(0, 1, 16'h02FF); step(0, 1, 16'h0300); step(0, 1, 16'h0301);
    chk("D_busy_before", busy, 1'b1);
    rst = 1'b0;
    step(0, 1, 16'h0302);
    rst = 1'b1;
    chk("D_busy", busy, 1'b0);
    chk("D_count", count, 0);
    chk("D_rd_valid", tif.rd_valid, 1'b0);
    step(0, 1, 16'h0303); step(0, 1, 16'h0300);
    chk("D_count_after", count, 0);

    // trigger disabled: buffer saturates and keeps running; arm clears it
    trig_en = 1'b0; trig_pc = 16'h0005;
    step(1, 0, 16'h0);
    for (int i = 0; i < 20; i++) step(0, 1, 16'(i % 10));
    chk("E_busy", busy, 1'b1);
    chk("E_count", count, 8);
    chk("E_triggered", triggered, 1'b0);
    step(1, 0, 16'h0);
    chk("E_count_rearm", count, 0);
    step(0, 1, 16'h0001);

    // randomized rounds
    for (int r = 0; r < 40; r++) begin
      trig_en  = ($urandom_range(0, 9) != 0);
      trig_pc  = 16'($urandom_range(0, 15));
      post_cnt = AW'($urandom_range(0, DEPTH - 1));
      step(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)));
      for (int c = 0; c < 60 && !done; c++) begin
        if ($urandom_range(0, 99) == 0) begin
          rst = 1'b0; step(0, 1, 16'h0); rst = 1'b1;
        end else if ($urandom_range(0, 79) == 0) begin
          step(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)));
        end else begin
          step(0, 1'($urandom_range(0, 2) != 0), 16'($urandom_range(0, 15)));
        end
      end
      if (done) begin
        if (r % 5 == 0) begin
          tif.rd_ready = 1'b1;
          step(0, 1, 16'h0); step(0, 0, 16'h0);
          tif.rd_ready = 1'b0;
          step(1, 0, 16'h0);
        end else begin
          drain(2, 200);
        end
      end
    end

    step(0, 0, 16'h0); step(0, 0, 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/debug_trace.md
DEBUG_TRACE -- requirements
Module: debug_trace

Interface
REQ-001 SHALL expose parameter DEPTH, default 16, trace buffer entries (power of two, >=2).
REQ-002 SHALL expose parameter CYC_W, default 32, cycle-stamp width.
REQ-003 SHALL provide port clk  input  1  single clock, all logic on posedge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL provide port fetch  input  1  instruction-boundary strobe, one cycle per fetch.
REQ-006 SHALL provide ports pc  input  16  program counter, ir  input  8  opcode, and flags  input  4  {Z N H C}.
REQ-007 SHALL provide ports arm  input  1  start/restart capture, trig_en  input  1  trigger enable, and trig_pc  input  16  trigger address.
REQ-008 SHALL provide port post_cnt  input  $clog2(DEPTH)  fetches to capture after trigger.
REQ-009 SHALL provide ports rd_valid  output  1, rd_ready  input  1, rd_last  output  1, and rd_data  output  ENT_W  readout stream.
REQ-010 SHALL provide ports busy  output  1  (ARMED or POST), done  output  1, triggered  output  1, and count  output  $clog2(DEPTH)+1  valid entries.

Function
REQ-011 Entry SHALL be {stamp[CYC_W-1:0], pc, ir, flags}, ENT_W = CYC_W+28, stamp in MSBs.
REQ-012 Cycle counter SHALL increment every clk, wrap at 2^CYC_W, clear to 0 on the cycle arm is sampled high.
REQ-013 FSM states SHALL be IDLE, ARMED, POST, DONE; arm sampled high in any state SHALL go to ARMED, clear wr_ptr, count, triggered, rd state.
REQ-014 A fetch coinciding with arm SHALL NOT be captured; capture starts the following cycle.
REQ-015 In ARMED/POST each fetch SHALL write the entry at wr_ptr on that edge, stamp = counter value before increment; wr_ptr wraps mod DEPTH; count saturates at DEPTH.
REQ-016 ARMED: fetch with trig_en=1 and pc==trig_pc SHALL capture that entry, set triggered, load remaining=post_cnt, go to POST, or straight to DONE if post_cnt==0.
REQ-017 POST: each fetch SHALL capture and decrement remaining; capture bringing remaining to 0 SHALL go to DONE.
REQ-018 IDLE and DONE SHALL ignore fetch.
REQ-019 DONE readout SHALL start at oldest entry (0 if count<DEPTH, else wr_ptr), present entries in capture order, rd_valid=1 while entries remain.
REQ-020 rd_data/rd_last SHALL hold stable while rd_valid=1 and rd_ready=0; transfer on rd_valid&rd_ready, advance next cycle.
REQ-021 rd_last SHALL be 1 only on the final entry; its transfer SHALL return FSM to IDLE; count SHALL decrement per transfer.
REQ-022 DONE with count==0 SHALL NOT occur (trigger entry always captured).
REQ-023 done SHALL be 1 exactly in DONE.

Reset
REQ-024 rst=0 at a posedge SHALL force IDLE, wr_ptr=0, rd_ptr=0, counter=0, and outputs busy=0, done=0, triggered=0, count=0, rd_valid=0, rd_last=0.
REQ-025 rd_data is don't-care under reset; buffer contents SHALL NOT be reset.
REQ-026 Reset mid-capture or mid-readout SHALL abandon the operation with no further writes.

Configuration
REQ-027 Macro DEBUG_TRACE_STAMP_EN defined: cycle counter and stamp field present as REQ-011/012.
REQ-028 Macro DEBUG_TRACE_STAMP_EN undefined: no counter, ENT_W = 28, entry = {pc, ir, flags}, all else unchanged.

Verification
REQ-029 DEPTH=8, arm, 3 fetches pc=0100..0102, trig_pc=0102, post_cnt=0 -> DONE, count=3, readout 0100,0101,0102, rd_last on third.
REQ-030 DEPTH=8, 12 fetches pc=0..B, trigger on pc=0009, post_cnt=2 -> count=8, readout pc 4..B in order, wrap verified.
REQ-031 Readout with rd_ready toggling 1,0,0,1 -> rd_data held across stalls, no entry lost or duplicated.
REQ-032 arm asserted on same cycle as fetch pc=0200, then fetch pc=0201 -> first stored entry pc=0201, stamp=0 (STAMP_EN), next fetch 3 cycles later stamp=3.
REQ-033 rst=0 during POST with 2 fetches remaining -> next cycle busy=0, count=0, rd_valid=0; following fetches ignored.
REQ-034 trig_en=0, 20 fetches including pc==trig_pc -> stays ARMED, count=8, triggered=0; arm mid-capture -> count=0.
